gcd_master: RTL and testbench
=============================

# gcd_master

Upstream sequencer for the GCD `slave` engine. It accepts operand pairs from a host over a valid/ready stream and buffers them in a small FIFO. It issues one request at a time to the slave, captures the slave's result, and presents it to the host on a second valid/ready stream. It also keeps a count of completed transactions.

## Interface
Parameters:
- `WIDTH`, 4, operand/result width; must equal the slave width.
- `DEPTH`, 4, input FIFO entries; power of two, ≥2.
- `TMO_CYCLES`, 64, watchdog limit in cycles; used only with `GCD_MASTER_TIMEOUT_EN`.

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `in_valid_i` in 1: host operand pair valid.
- `in_ready_o` out 1: FIFO can accept a pair.
- `in_a_i`, `in_b_i` in WIDTH: host operands.
- `res_valid_o` out 1: result held for the host.
- `res_ready_i` in 1: host accepts the result.
- `res_data_o` out WIDTH: GCD result.
- `gcd_req_o` out 1: request to slave (`req_i`).
- `gcd_op_a_o`, `gcd_op_b_o` out WIDTH: operands to slave.
- `gcd_busy_i` in 1: slave `busy_o`.
- `gcd_valid_i` in 1: slave `valid_o`.
- `gcd_result_i` in WIDTH: slave `result_val_o`.
- `done_cnt_o` out 8: completed transactions, wraps at 255→0.
- `err_o` out 1: result was produced by a timeout; present only with `GCD_MASTER_TIMEOUT_EN`.

## Operation
- **FIFO**
  - Holds DEPTH operand pairs, with registered read and write pointers plus a count.
  - A push happens when `in_valid_i && in_ready_o`.
  - `in_ready_o = (count != DEPTH)`.
  - When full, a push is refused even if a pop happens in the same cycle.
  - A push and a pop in the same cycle are allowed when the FIFO is neither empty nor full; the count is unchanged.
  - There is no bypass: a pair pushed in cycle N is poppable no earlier than cycle N+1.
- **State machine** (one transaction in flight):
  - IDLE: if FIFO is non-empty, pop into the operand register and go to ISSUE.
  - ISSUE: `gcd_req_o=1`, operands driven from the operand register.
    - If `gcd_busy_i=0`, go to WAIT. The slave samples the operands this cycle.
    - Otherwise stay in ISSUE with req held.
  - WAIT: `gcd_req_o=0`. On `gcd_valid_i=1`, capture `gcd_result_i` into the result register, increment `done_cnt_o`, and go to HOLD.
  - HOLD: `res_valid_o=1`; data is stable until the handshake. On `res_ready_i=1`, go to IDLE.
- `gcd_op_a_o` and `gcd_op_b_o` come only from the operand register, never directly from the FIFO head.
- `gcd_valid_i` is ignored in IDLE, ISSUE and HOLD.
- Zero operands are forwarded unchanged. The slave's result is authoritative.

## Timing
- **Reset values:**
  - `in_ready_o=1` (FIFO empty).
  - `res_valid_o=0`, `res_data_o=0`, `gcd_req_o=0`.
  - `gcd_op_a_o=0`, `gcd_op_b_o=0`.
  - `done_cnt_o=0`, `err_o=0`.
  - State is IDLE and FIFO pointers are cleared.
- **Reset mid-operation:** the FIFO contents and any in-flight transaction are discarded. The slave's own reset is separate; the bench must reset both together.
- **Latency:**
  - Push in cycle 0 with the FIFO empty and state IDLE → pop at the end of cycle 1 → `gcd_req_o` high in cycle 2.
  - Slave valid in cycle K → `res_valid_o` high in cycle K+1.
  - HOLD→IDLE takes one cycle. The next pop happens in that IDLE cycle, so back-to-back requests are spaced by (slave time + 3) cycles.
- All outputs are registered except `in_ready_o`, which is derived from the registered count.

## Configuration
- **`GCD_MASTER_TIMEOUT_EN` defined:**
  - A cycle counter runs in WAIT.
  - If TMO_CYCLES cycles elapse without `gcd_valid_i`, the block moves to HOLD with `res_data_o=0` and `err_o=1`.
  - `done_cnt_o` still increments.
  - `err_o` is valid with `res_valid_o` and clears when the handshake completes.
  - A late `gcd_valid_i` arriving after the timeout is ignored.
- **Not defined:**
  - The `err_o` port and the counter do not exist.
  - WAIT lasts indefinitely.

## Test plan
- **Single transaction:** reset, push (12,8) → `gcd_req_o` 2 cycles later, `res_data_o=4` with `res_valid_o`, `done_cnt_o=1`.
- **Burst:** push (9,6), (15,5), (7,3), (8,8) back-to-back → `in_ready_o` stays high and results 3, 5, 1, 8 appear in order, one request in flight at a time.
- **Back-pressure:** hold `res_ready_i=0` after the first result and push 5 pairs → `in_ready_o` drops after 4 pushes and `res_data_o` stays stable. Release → all 5 results drain in order.
- **Busy stall:** force `gcd_busy_i=1` for 3 cycles while in ISSUE → `gcd_req_o` is held with stable operands for 4 cycles and only one slave sample occurs.
- **Reset mid-operation:** assert `rst_i` during WAIT with 2 pairs queued → all outputs return to reset values the next cycle, and a new push of (6,4) completes with result 2.
- **Timeout (`GCD_MASTER_TIMEOUT_EN`, TMO_CYCLES=8):** the slave model never asserts valid → `res_valid_o` is high with `err_o=1` and `res_data_o=0`. The next transaction (10,4) returns 2 with `err_o=0`.

Source files
------------

// File: rtl/gcd_master.sv
// gcd_master: host-facing sequencer for the GCD slave engine.
// Buffers operand pairs in a small FIFO, issues one slave request at a time,
// holds each result for the host and counts completed transactions.
// Optional feature: define GCD_MASTER_TIMEOUT_EN to add a WAIT watchdog and err_o.
module gcd_master #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned TMO_CYCLES = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] res_data_o,
    output logic             gcd_req_o,
    output logic [WIDTH-1:0] gcd_op_a_o,
    output logic [WIDTH-1:0] gcd_op_b_o,
    input  logic             gcd_busy_i,
    input  logic             gcd_valid_i,
    input  logic [WIDTH-1:0] gcd_result_i,
`ifdef GCD_MASTER_TIMEOUT_EN
    output logic             err_o,
`endif
    output logic [7:0]       done_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // Reject parameter sets the pointer arithmetic cannot support
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TMO_CYCLES == 0 || WIDTH == 0) begin : g_bad_params
        $error("gcd_master: DEPTH must be a power of two >= 2, WIDTH and TMO_CYCLES non-zero");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t state_q, state_n;

    logic [WIDTH-1:0] fifo_a_q [DEPTH];
    logic [WIDTH-1:0] fifo_b_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic push;
    logic pop;
    logic capture;

`ifdef GCD_MASTER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TMO_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             expire;
`endif

    // Ready depends only on the registered count, so a full FIFO refuses pushes even during a pop
    assign in_ready_o = (count_q != CNT_W'(DEPTH));
    assign push       = in_valid_i && in_ready_o;

    // FIFO storage; data needs no reset since count gates every read
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_a_q[wr_ptr_q] <= in_a_i;
            fifo_b_q[wr_ptr_q] <= in_b_i;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state logic and per-cycle strobes
    always_comb begin
        state_n = state_q;
        pop     = 1'b0;
        capture = 1'b0;
`ifdef GCD_MASTER_TIMEOUT_EN
        expire  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!gcd_busy_i) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (gcd_valid_i) begin
                    capture = 1'b1;
                    state_n = S_HOLD;
                end
`ifdef GCD_MASTER_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_W'(TMO_CYCLES - 1)) begin
                    expire  = 1'b1;
                    state_n = S_HOLD;
                end
`endif
            end
            S_HOLD: begin
                if (res_ready_i) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

`ifdef GCD_MASTER_TIMEOUT_EN
    // Watchdog counts consecutive WAIT cycles and restarts on every entry
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
        end else if (state_q == S_WAIT && state_n == S_WAIT) begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    // Error flag travels with the held result and drops on the host handshake
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (expire) begin
            err_o <= 1'b1;
        end else if (capture || (state_q == S_HOLD && res_ready_i)) begin
            err_o <= 1'b0;
        end
    end
`endif

    // Registered outputs, decoded from the next state so they align with it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gcd_req_o   <= 1'b0;
            res_valid_o <= 1'b0;
            gcd_op_a_o  <= '0;
            gcd_op_b_o  <= '0;
            res_data_o  <= '0;
            done_cnt_o  <= '0;
        end else begin
            gcd_req_o   <= (state_n == S_ISSUE);
            res_valid_o <= (state_n == S_HOLD);
            if (pop) begin
                gcd_op_a_o <= fifo_a_q[rd_ptr_q];
                gcd_op_b_o <= fifo_b_q[rd_ptr_q];
            end
            if (capture) begin
                res_data_o <= gcd_result_i;
                done_cnt_o <= done_cnt_o + 8'd1;
            end
`ifdef GCD_MASTER_TIMEOUT_EN
            if (expire) begin
                res_data_o <= '0;
                done_cnt_o <= done_cnt_o + 8'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_gcd_master.sv
// Directed testbench for gcd_master with a behavioural GCD slave model.
`timescale 1ns/1ps
module tb_gcd_master;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 8;
    localparam int          LAT   = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a, in_b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             gcd_req;
    logic [WIDTH-1:0] op_a, op_b;
    logic             gcd_busy;
    logic             gcd_valid;
    logic [WIDTH-1:0] gcd_result;
    logic [7:0]       done_cnt;
    logic             err;

    // Slave model state
    logic force_busy;
    logic mute;
    logic m_busy;
    int   m_cnt;
    int   sample_cnt  = 0;
    int   overlap_cnt = 0;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_done = 0;

    always #5 clk = ~clk;

    gcd_master #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .TMO_CYCLES(TMO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .in_valid_i(in_valid),
        .in_ready_o(in_ready),
        .in_a_i(in_a),
        .in_b_i(in_b),
        .res_valid_o(res_valid),
        .res_ready_i(res_ready),
        .res_data_o(res_data),
        .gcd_req_o(gcd_req),
        .gcd_op_a_o(op_a),
        .gcd_op_b_o(op_b),
        .gcd_busy_i(gcd_busy),
        .gcd_valid_i(gcd_valid),
        .gcd_result_i(gcd_result),
`ifdef GCD_MASTER_TIMEOUT_EN
        .err_o(err),
`endif
        .done_cnt_o(done_cnt)
    );

`ifndef GCD_MASTER_TIMEOUT_EN
    assign err = 1'b0;
`endif

    function automatic logic [WIDTH-1:0] gcd_ref(input logic [WIDTH-1:0] a_in, input logic [WIDTH-1:0] b_in);
        logic [WIDTH-1:0] a, b, t;
        a = a_in;
        b = b_in;
        while (b != '0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    assign gcd_busy = m_busy | force_busy;

    // Slave model: samples on req && !busy, answers LAT+1 cycles later with a one-cycle valid
    always @(posedge clk) begin
        gcd_valid <= 1'b0;
        if (rst) begin
            m_busy     <= 1'b0;
            m_cnt      <= 0;
            gcd_result <= '0;
        end else if (m_busy) begin
            if (gcd_req) overlap_cnt <= overlap_cnt + 1;
            if (m_cnt == 0) begin
                m_busy    <= 1'b0;
                gcd_valid <= !mute;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (gcd_req && !force_busy) begin
            m_busy     <= 1'b1;
            m_cnt      <= LAT;
            gcd_result <= gcd_ref(op_a, op_b);
            sample_cnt <= sample_cnt + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_in_ready"}, in_ready, 1);
        check({name, "_res_valid"}, res_valid, 0);
        check({name, "_res_data"}, res_data, 0);
        check({name, "_req"}, gcd_req, 0);
        check({name, "_op_a"}, op_a, 0);
        check({name, "_op_b"}, op_b, 0);
        check({name, "_done_cnt"}, done_cnt, 0);
`ifdef GCD_MASTER_TIMEOUT_EN
        check({name, "_err"}, err, 0);
`endif
    endtask

    task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !in_ready; i++) step();
        check("push_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_res(input string name);
        for (int i = 0; i < 200 && !res_valid; i++) step();
        check({name, "_valid"}, res_valid, 1);
    endtask

    task automatic take_result(input string name, input logic [WIDTH-1:0] exp, input logic exp_err);
        wait_res(name);
        check({name, "_data"}, res_data, exp);
        exp_done = (exp_done + 1) % 256;
        check({name, "_done_cnt"}, done_cnt, exp_done);
`ifdef GCD_MASTER_TIMEOUT_EN
        check({name, "_err"}, err, exp_err);
`else
        if (exp_err) $display("note: error flag not built");
`endif
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check({name, "_valid_drop"}, res_valid, 0);
    endtask

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp;
    } vec_t;

    vec_t vecs[7];
    vec_t burst[4];
    vec_t bp[5];

    initial begin
        int hi;
        int s0;
        int stray;

        vecs[0] = '{a: 4'd0,  b: 4'd5,  exp: 4'd5};
        vecs[1] = '{a: 4'd7,  b: 4'd0,  exp: 4'd7};
        vecs[2] = '{a: 4'd0,  b: 4'd0,  exp: 4'd0};
        vecs[3] = '{a: 4'd15, b: 4'd15, exp: 4'd15};
        vecs[4] = '{a: 4'd1,  b: 4'd15, exp: 4'd1};
        vecs[5] = '{a: 4'd14, b: 4'd10, exp: 4'd2};
        vecs[6] = '{a: 4'd12, b: 4'd15, exp: 4'd3};

        burst[0] = '{a: 4'd9,  b: 4'd6, exp: 4'd3};
        burst[1] = '{a: 4'd15, b: 4'd5, exp: 4'd5};
        burst[2] = '{a: 4'd7,  b: 4'd3, exp: 4'd1};
        burst[3] = '{a: 4'd8,  b: 4'd8, exp: 4'd8};

        bp[0] = '{a: 4'd6,  b: 4'd9,  exp: 4'd3};
        bp[1] = '{a: 4'd8,  b: 4'd12, exp: 4'd4};
        bp[2] = '{a: 4'd14, b: 4'd7,  exp: 4'd7};
        bp[3] = '{a: 4'd3,  b: 4'd5,  exp: 4'd1};
        bp[4] = '{a: 4'd4,  b: 4'd10, exp: 4'd2};

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        res_ready  = 1'b0;
        force_busy = 1'b0;
        mute       = 1'b0;
        step();
        step();
        check_reset_values("reset");
        rst = 1'b0;

        // Single transaction with latency: push cycle 0, req in cycle 2
        in_a     = 4'd12;
        in_b     = 4'd8;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("lat_req_c1", gcd_req, 0);
        step();
        check("lat_req_c2", gcd_req, 1);
        check("lat_op_a", op_a, 12);
        check("lat_op_b", op_b, 8);
        take_result("single", 4'd4, 1'b0);

        // Table of single transactions, including zero operands
        for (int i = 0; i < 7; i++) begin
            push(vecs[i].a, vecs[i].b);
            take_result($sformatf("vec%0d", i), vecs[i].exp, 1'b0);
        end

        // Burst: four back-to-back pushes never see back-pressure
        for (int i = 0; i < 4; i++) begin
            in_a     = burst[i].a;
            in_b     = burst[i].b;
            in_valid = 1'b1;
            check($sformatf("burst_ready%0d", i), in_ready, 1);
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) take_result($sformatf("burst%0d", i), burst[i].exp, 1'b0);

        // Back-pressure: result held while FIFO fills to DEPTH
        push(4'd10, 4'd15);
        wait_res("bp_first");
        check("bp_first_data", res_data, 5);
        exp_done = (exp_done + 1) % 256;
        check("bp_first_done", done_cnt, exp_done);
        for (int i = 0; i < 4; i++) begin
            in_a     = bp[i].a;
            in_b     = bp[i].b;
            in_valid = 1'b1;
            check($sformatf("bp_ready%0d", i), in_ready, 1);
            step();
        end
        check("bp_full_ready", in_ready, 0);
        in_a = bp[4].a;
        in_b = bp[4].b;
        step();
        step();
        check("bp_still_full", in_ready, 0);
        check("bp_hold_data", res_data, 5);
        check("bp_hold_valid", res_valid, 1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        push(bp[4].a, bp[4].b);
        for (int i = 0; i < 5; i++) take_result($sformatf("bp%0d", i), bp[i].exp, 1'b0);

        // Busy stall: req and operands held for 4 cycles, one slave sample
        force_busy = 1'b1;
        push(4'd12, 4'd9);
        for (int i = 0; i < 20 && !gcd_req; i++) step();
        hi = 0;
        for (int k = 0; k < 3; k++) begin
            check("stall_req", gcd_req, 1);
            check("stall_op_a", op_a, 12);
            check("stall_op_b", op_b, 9);
            hi += int'(gcd_req);
            step();
        end
        force_busy = 1'b0;
        check("stall_req_last", gcd_req, 1);
        hi += int'(gcd_req);
        s0 = sample_cnt;
        step();
        check("stall_req_drop", gcd_req, 0);
        check("stall_req_cycles", hi, 4);
        check("stall_samples", sample_cnt - s0, 1);
        take_result("stall", 4'd3, 1'b0);

        // Reset during WAIT with two pairs queued
        push(4'd12, 4'd8);
        push(4'd9, 4'd6);
        push(4'd15, 4'd5);
        check("midrst_wait_req", gcd_req, 0);
        check("midrst_wait_busy", m_busy, 1);
        rst = 1'b1;
        step();
        check_reset_values("midrst");
        rst      = 1'b0;
        exp_done = 0;
        push(4'd6, 4'd4);
        take_result("post_rst", 4'd2, 1'b0);
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            stray += int'(gcd_req) + int'(res_valid);
            step();
        end
        check("post_rst_flushed", stray, 0);

`ifdef GCD_MASTER_TIMEOUT_EN
        // Timeout: slave never answers
        mute = 1'b1;
        push(4'd12, 4'd8);
        take_result("timeout", 4'd0, 1'b1);
        mute = 1'b0;
        push(4'd10, 4'd4);
        take_result("after_tmo", 4'd2, 1'b0);
`endif

        check("one_in_flight", overlap_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
